// File: rtl/blinkled_data_memory_arbiter_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
// Used by the top level and by the round-robin sub-module.
package blinkled_data_memory_arbiter_pkg;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DMA = 1'b1
   } port_e;

   localparam int unsigned MAX_BURST_MIN = 1;
   localparam int unsigned MAX_BURST_MAX = 15;
   localparam int unsigned BURST_CNT_W   = 4;

   function automatic int unsigned be_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Out-of-range burst limits are pulled into the supported window.
   function automatic int unsigned clamp_burst(input int unsigned mb);
      if (mb < MAX_BURST_MIN) return MAX_BURST_MIN;
      if (mb > MAX_BURST_MAX) return MAX_BURST_MAX;
      return mb;
   endfunction

endpackage

// File: rtl/blinkled_data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with bounded burst ownership.
// Grant is combinational; owner and burst count advance only while accept is high.
module blinkled_data_memory_arbiter_rr_arbiter2
   import blinkled_data_memory_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(clamp_burst(MAX_BURST));

   port_e                  last_grant;
   port_e                  win;
   logic                   any_grant;
   logic [BURST_CNT_W-1:0] burst_cnt;
   logic [BURST_CNT_W-1:0] burst_cnt_nxt;

   always_comb begin
      win       = last_grant;
      any_grant = 1'b0;
      if (accept) begin
         case (req)
            2'b01: begin
               win       = PORT_CPU;
               any_grant = 1'b1;
            end
            2'b10: begin
               win       = PORT_DMA;
               any_grant = 1'b1;
            end
            2'b11: begin
               any_grant = 1'b1;
               // Current owner keeps the memory until its burst allowance is used up.
               if (burst_cnt < BURST_LIMIT) win = last_grant;
               else                         win = (last_grant == PORT_CPU) ? PORT_DMA : PORT_CPU;
            end
            default: ;
         endcase
      end

      grant[0] = any_grant && (win == PORT_CPU);
      grant[1] = any_grant && (win == PORT_DMA);

      burst_cnt_nxt = burst_cnt;
      if (accept) begin
         if (!any_grant)                 burst_cnt_nxt = '0;
         else if (win != last_grant)     burst_cnt_nxt = BURST_CNT_W'(1);
         else if (burst_cnt < BURST_LIMIT) burst_cnt_nxt = burst_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= PORT_CPU;
         burst_cnt  <= '0;
      end else begin
         burst_cnt <= burst_cnt_nxt;
         if (any_grant) last_grant <= win;
      end
   end

endmodule

// File: rtl/blinkled_data_memory_arbiter.sv
// Shares a single-port 1-cycle-latency data memory between the CPU and DMA Avalon-MM masters,
// presenting each as a pipelined port (waitrequest + readdatavalid).
module blinkled_data_memory_arbiter
   import blinkled_data_memory_arbiter_pkg::*;
#(
   parameter  int unsigned ADDR_W    = 16,
   parameter  int unsigned DATA_W    = 32,
   parameter  int unsigned MAX_BURST = 4,
   localparam int unsigned BE_W      = be_width(DATA_W)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              reset_req,

   input  logic [ADDR_W-1:0] s0_address,
   input  logic [BE_W-1:0]   s0_byteenable,
   input  logic              s0_read,
   input  logic              s0_write,
   input  logic [DATA_W-1:0] s0_writedata,
   output logic              s0_waitrequest,
   output logic [DATA_W-1:0] s0_readdata,
   output logic              s0_readdatavalid,

   input  logic [ADDR_W-1:0] s1_address,
   input  logic [BE_W-1:0]   s1_byteenable,
   input  logic              s1_read,
   input  logic              s1_write,
   input  logic [DATA_W-1:0] s1_writedata,
   output logic              s1_waitrequest,
   output logic [DATA_W-1:0] s1_readdata,
   output logic              s1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic [1:0] req;
   logic [1:0] grant;
   logic       arb_enable;
   logic       sel_dma;
   logic       sel_write;
   logic       rd_pending;
   port_e      rd_port;

   // reset_n also gates grants so both ports stall while reset is held.
   assign arb_enable = reset_n & ~reset_req;
   assign req        = {s1_read | s1_write, s0_read | s0_write};

   blinkled_data_memory_arbiter_rr_arbiter2 #(
      .MAX_BURST (MAX_BURST)
   ) u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .accept  (arb_enable),
      .grant   (grant)
   );

   assign s0_waitrequest = ~grant[0];
   assign s1_waitrequest = ~grant[1];
   assign mem_clken      = ~reset_req;

   always_comb begin
      sel_dma        = grant[1];
      mem_chipselect = |grant;
      sel_write      = sel_dma ? s1_write : s0_write;
      mem_address    = sel_dma ? s1_address : s0_address;
      mem_writedata  = sel_dma ? s1_writedata : s0_writedata;
      mem_write      = mem_chipselect & sel_write;
      mem_byteenable = '1;
      if (sel_write) mem_byteenable = sel_dma ? s1_byteenable : s0_byteenable;
   end

   // Read/write together is issued as a write, so no return is scheduled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pending <= 1'b0;
         rd_port    <= PORT_CPU;
      end else begin
         rd_pending <= mem_chipselect & ~mem_write;
         if (mem_chipselect) rd_port <= sel_dma ? PORT_DMA : PORT_CPU;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s0_readdatavalid <= 1'b0;
         s1_readdatavalid <= 1'b0;
         s0_readdata      <= '0;
         s1_readdata      <= '0;
      end else begin
         s0_readdatavalid <= rd_pending && (rd_port == PORT_CPU);
         s1_readdatavalid <= rd_pending && (rd_port == PORT_DMA);
         if (rd_pending && (rd_port == PORT_CPU)) s0_readdata <= mem_readdata;
         if (rd_pending && (rd_port == PORT_DMA)) s1_readdata <= mem_readdata;
      end
   end

endmodule
